// File: rtl/btn_event_gen.sv
// btn_event_gen: turns a debounced button level into one-cycle press / short /
// long / repeat event strobes plus a registered "held" level.
// Latency: every output is registered, one cycle after the deciding clk edge.
// Backpressure: none; strobes are fire-and-forget and are never stalled.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   btn_stable   debounced button level, already in the clk domain
//   press_pulse  one-cycle strobe on each accepted press (rising edge)
//   short_pulse  one-cycle strobe on release before the long threshold
//   long_pulse   one-cycle strobe when the hold reaches LONG_CYCLES
//   repeat_pulse one-cycle strobe every REPEAT_CYCLES after long_pulse
//   held         high while a press is in progress (PRESSED or LONG)
//
// Configuration macro: BTN_EVENT_REPEAT_EN
//   defined   - LONG state emits repeat_pulse every REPEAT_CYCLES clocks
//   undefined - repeat_pulse tied low, cnt parked at 0 while in LONG
module btn_event_gen #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_stable,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             btn_q;
  logic             rise;

  logic press_nxt;
  logic short_nxt;
  logic long_nxt;
  logic repeat_nxt;
  logic held_nxt;

  // btn_q resets to 1 so a button already held through reset is not
  // mistaken for a fresh press; a release must be seen first.
  assign rise = btn_stable & ~btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_q        <= 1'b1;
      press_pulse  <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      btn_q        <= btn_stable;
      press_pulse  <= press_nxt;
      short_pulse  <= short_nxt;
      long_pulse   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      held         <= held_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_nxt  = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;

    case (state)
      IDLE: begin
        // A fall while idle carries no meaning and is ignored.
        if (rise) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      end

      PRESSED: begin
        // Release is tested first so a release coinciding with the long
        // threshold is reported as a short press.
        if (!btn_stable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      LONG: begin
        // Release after a long press ends silently.
        if (!btn_stable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
`ifdef BTN_EVENT_REPEAT_EN
          if (cnt == REPEAT_LAST) begin
            cnt_nxt    = '0;
            repeat_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`else
          cnt_nxt = '0;
`endif
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    held_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: randomized + directed stimulus for btn_event_gen, scored
// against an elapsed-time reference model through an expected-output queue.
// The monitor pops one expected vector per clock and compares all outputs.
module tb_btn_event_gen;

  localparam int L = 8;
  localparam int R = 3;
`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_stable = 1'b0;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, held;

  always #5 clk = ~clk;

  btn_event_gen #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_stable  (btn_stable),
    .press_pulse (press_pulse),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  // Expected vector layout: {press, short, long, repeat, held}
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: whether a press is in progress, the previous level,
  // and how many clock edges have passed since the press edge.
  bit m_hold = 1'b0;
  bit m_prev = 1'b1;
  int m_d    = 0;

  task automatic step(input logic b, input logic r);
    logic [4:0] e;
    @(negedge clk);
    btn_stable = b;
    rst        = r;
    e          = '0;
    if (r) begin
      m_hold = 1'b0;
      m_prev = 1'b1;
      m_d    = 0;
    end else begin
      if (!m_hold) begin
        if (b && !m_prev) begin
          e[4]   = 1'b1;
          m_hold = 1'b1;
          m_d    = 0;
        end
      end else begin
        m_d = m_d + 1;
        if (!b) begin
          if (m_d <= L) e[3] = 1'b1;
          m_hold = 1'b0;
        end else if (m_d == L) begin
          e[2] = 1'b1;
        end else if (REP_EN && m_d > L && ((m_d - L) % R) == 0) begin
          e[1] = 1'b1;
        end
      end
      m_prev = b;
      e[0]   = m_hold;
    end
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  // Monitor: outputs settle after posedge; compare at the following negedge.
  initial begin : monitor
    logic [4:0] e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {press_pulse, short_pulse, long_pulse, repeat_pulse, held};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d {press,short,long,repeat,held} got=%b want=%b",
                   cyc, act, e);
        end
        n_checks++;
        if ($countones(act[4:1]) > 1) begin
          n_fail++;
          $display("FAIL one_strobe cyc=%0d strobes got=%b want at most one set",
                   cyc, act[4:1]);
        end
      end
    end
  end

  initial begin : stimulus
    int w;
    int hi;
    int lo;

    // Reset hold with button released.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    run(1'b0, 3);

    // Short press: high 4 cycles.
    run(1'b1, 4);
    run(1'b0, 5);

    // Single-cycle high.
    run(1'b1, 1);
    run(1'b0, 4);

    // Long hold with repeats.
    run(1'b1, 20);
    run(1'b0, 5);

    // Release exactly at the long threshold.
    run(1'b1, L);
    run(1'b0, 5);

    // Release one cycle after the threshold: long fires, no short.
    run(1'b1, L + 1);
    run(1'b0, 4);

    // Held through reset, then release and a new press.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    run(1'b1, 20);
    run(1'b0, 2);
    run(1'b1, 4);
    run(1'b0, 3);

    // Reset mid-hold: no short pulse for the aborted press.
    run(1'b1, 5);
    step(1'b1, 1'b1);
    run(1'b0, 4);

    // Randomized segments, with the occasional reset.
    for (int s = 0; s < 60; s++) begin
      hi = $urandom_range(1, 2 * L + 3 * R);
      lo = $urandom_range(1, 4);
      run(1'b1, hi);
      if ($urandom_range(0, 9) == 0) step($urandom_range(0, 1) == 1, 1'b1);
      run(1'b0, lo);
    end
    run(1'b0, 3);

    // Drain the scoreboard with a bounded wait.
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
